// File: rtl/platform_pkg.sv
// Platform constants shared by the core, interconnect and slaves.
// Slave order: DMEM, MTIMER, LED driver, WBUART.
package platform_pkg;

  localparam int unsigned NUM_SLAVES = 4;

  localparam int unsigned DMEM_IDX   = 0;
  localparam int unsigned MTIMER_IDX = 1;
  localparam int unsigned LED_IDX    = 2;
  localparam int unsigned UART_IDX   = 3;

  localparam logic [NUM_SLAVES-1:0][31:0] START_ADDRESS = {
    32'hA000_0020,
    32'hA000_0010,
    32'hA000_0000,
    32'h9000_0000
  };

  localparam logic [NUM_SLAVES-1:0][31:0] MASK = {
    32'hFFFF_FFE0,
    32'hFFFF_FFF0,
    32'hFFFF_FFF0,
    32'hF000_0000
  };

  localparam int unsigned WB_MAX_OUTSTANDING = 4;
  localparam int unsigned WB_TIMEOUT_CYCLES  = 256;

  typedef logic [$clog2(NUM_SLAVES)-1:0] slave_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DECERR,
    ST_ABORT
  } wb_state_t;

  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Base/mask address decoder; the lowest matching slave index wins.
module wb_addr_decoder
  import platform_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = platform_pkg::NUM_SLAVES
) (
  input  logic [31:0]                 adr_i,
  input  logic [NUM_SLAVES-1:0][31:0] base_i,
  input  logic [NUM_SLAVES-1:0][31:0] mask_i,
  output logic [idx_w(NUM_SLAVES)-1:0] idx_o,
  output logic                        hit_o
);

  localparam int unsigned IW = idx_w(NUM_SLAVES);

  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((adr_i & mask_i[i]) == (base_i[i] & mask_i[i])) begin
        idx_o = IW'(i);
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_interconnect.sv
// Pipelined Wishbone B4 1:N interconnect with outstanding tracking,
// decode-error responses and a bus timeout.
module wb_interconnect #(
  parameter int unsigned NUM_SLAVES = platform_pkg::NUM_SLAVES,
  parameter logic [NUM_SLAVES-1:0][31:0] START_ADDRESS =
    platform_pkg::START_ADDRESS,
  parameter logic [NUM_SLAVES-1:0][31:0] MASK = platform_pkg::MASK,
  parameter int unsigned MAX_OUTSTANDING =
    platform_pkg::WB_MAX_OUTSTANDING,
  parameter int unsigned TIMEOUT_CYCLES =
    platform_pkg::WB_TIMEOUT_CYCLES
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     m_cyc_i,
  input  logic                     m_stb_i,
  input  logic                     m_we_i,
  input  logic [31:0]              m_adr_i,
  input  logic [31:0]              m_dat_i,
  input  logic [3:0]               m_sel_i,
  output logic                     m_stall_o,
  output logic                     m_ack_o,
  output logic                     m_err_o,
  output logic [31:0]              m_dat_o,
  output logic [NUM_SLAVES-1:0]    s_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_stb_o,
  output logic                     s_we_o,
  output logic [31:0]              s_adr_o,
  output logic [31:0]              s_dat_o,
  output logic [3:0]               s_sel_o,
  input  logic [NUM_SLAVES-1:0]    s_stall_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i,
  input  logic [NUM_SLAVES-1:0]    s_err_i,
  input  logic [NUM_SLAVES*32-1:0] s_dat_i
);

  import platform_pkg::*;

  localparam int unsigned IW = idx_w(NUM_SLAVES);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] OUT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TMO_LAST =
    (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  logic [IW-1:0] idx;
  logic          hit;
  logic [IW-1:0] sel_q, sel_d;
  wb_state_t     state_q, state_d;
  logic [CW-1:0] out_q, out_d, out_nxt;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          abort_q, abort_d;

  logic busy, block, tgt_stall, accept;
  logic active, ack_sel, err_sel, resp, tmo_hit;

  wb_addr_decoder #(
    .NUM_SLAVES(NUM_SLAVES)
  ) u_dec (
    .adr_i (m_adr_i),
    .base_i(START_ADDRESS),
    .mask_i(MASK),
    .idx_o (idx),
    .hit_o (hit)
  );

  always_comb begin
    busy = (out_q != '0);
    block = (busy && (!hit || idx != sel_q))
         || (out_q == OUT_MAX)
         || (state_q == ST_DECERR)
         || (state_q == ST_ABORT);
    tgt_stall = hit & s_stall_i[idx];
    m_stall_o = rstn_i & (block | tgt_stall);
    accept = rstn_i & m_cyc_i & m_stb_i & ~(block | tgt_stall);

    active  = (state_q == ST_ACTIVE) && busy && m_cyc_i;
    ack_sel = active & s_ack_i[sel_q];
    err_sel = active & s_err_i[sel_q];
    resp    = ack_sel | err_sel;
    tmo_hit = (TIMEOUT_CYCLES > 0) && busy
           && (tmo_q == TMO_LAST) && !resp;

    m_ack_o = ack_sel;
    m_err_o = err_sel
           | (state_q == ST_DECERR)
           | ((state_q == ST_ABORT) & abort_q);
    m_dat_o = active ? s_dat_i[32*sel_q +: 32] : '0;

    s_stb_o = '0;
    if (accept && hit) s_stb_o[idx] = 1'b1;
    s_cyc_o = s_stb_o;
    if (state_q == ST_ACTIVE && rstn_i) s_cyc_o[sel_q] = m_cyc_i;

    // Broadcast lines are held low in reset as well.
    s_we_o  = rstn_i & m_we_i;
    s_adr_o = rstn_i ? m_adr_i : '0;
    s_dat_o = rstn_i ? m_dat_i : '0;
    s_sel_o = rstn_i ? m_sel_i : '0;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    out_d   = out_q;
    tmo_d   = '0;
    abort_d = 1'b0;
    out_nxt = out_q + CW'(accept) - CW'(resp);
    if (!m_cyc_i) begin
      state_d = ST_IDLE;
      out_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept && hit) begin
            state_d = ST_ACTIVE;
            sel_d   = idx;
            out_d   = CW'(1);
          end else if (accept) begin
            state_d = ST_DECERR;
          end
        end
        ST_ACTIVE: begin
          if (tmo_hit) begin
            state_d = ST_ABORT;
            out_d   = '0;
            abort_d = 1'b1;
          end else begin
            out_d = out_nxt;
            if (out_nxt == '0) state_d = ST_IDLE;
            if (!resp && busy && TIMEOUT_CYCLES > 0)
              tmo_d = tmo_q + 1'b1;
          end
        end
        ST_DECERR: state_d = ST_IDLE;
        ST_ABORT:  out_d = '0;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      out_q   <= '0;
      tmo_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      tmo_q   <= tmo_d;
      abort_q <= abort_d;
    end
  end

endmodule
